// File: rtl/vmem_pkg.sv
// Shared types and helpers for the video memory arbiter.
// Optional build macro used by the arbiter: VMEM_ARB_STATS_EN.
package vmem_pkg;

  localparam int VMEM_ADDR_W = 19;
  localparam int VMEM_DATA_W = 24;

  typedef logic [VMEM_DATA_W-1:0] pixel_t;
  typedef logic [VMEM_ADDR_W-1:0] vmem_addr_t;

  // Framebuffer address from scan position: {h, v}
  function automatic vmem_addr_t vmem_addr(
    input logic [9:0] h,
    input logic [8:0] v
  );
    return {h, v[8:0]};
  endfunction

endpackage

// File: rtl/vmem_arbiter_starve_timer.sv
// Writer starvation timer: counts consecutive denied writer cycles
// and raises force_gnt once the count reaches MAX_WAIT (0 = never).
module starve_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic stall,
  input  logic done,
  output logic force_gnt
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXV = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign force_gnt = (MAX_WAIT != 0) && (cnt_q == MAXV);

  // Clear on drop or handshake, otherwise saturating count of stalls
  always_comb begin
    cnt_d = cnt_q;
    if (!req || done) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != MAXV)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port video memory arbiter: display reads first, writer in
// idle cycles or when forced. Optional stats via VMEM_ARB_STATS_EN.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int ADDR_W   = VMEM_ADDR_W,
  parameter int DATA_W   = VMEM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_stale,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stale_cnt,
  output logic [15:0]       force_cnt
`endif
);

  logic force_gnt;
  logic grant_w;
  logic grant_d;
  logic handshake;

  logic              rd_pend_q, rd_pend_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stale_q, stale_d;

  // Grants are held low during reset so the RAM stays idle
  assign grant_w   = resetn && (!disp_req || force_gnt);
  assign grant_d   = resetn && disp_req && !grant_w;
  assign handshake = wr_valid && grant_w;
  assign wr_ready  = grant_w;

  starve_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .req       (wr_valid),
    .stall     (wr_valid && !grant_w),
    .done      (handshake),
    .force_gnt (force_gnt)
  );

  // RAM port drive from the winning requester
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      grant_d: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end
      handshake: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      default: ;
    endcase
  end

  // Read return: fresh data, or hold and flag stale when denied
  always_comb begin
    rd_pend_d = grant_d;
    req_d     = disp_req;
    data_d    = data_q;
    stale_d   = stale_q;
    if (rd_pend_q) begin
      data_d  = mem_rdata;
      stale_d = 1'b0;
    end else if (req_q) begin
      stale_d = 1'b1;
    end
  end

  // Read return registers; reset drops any pending read
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pend_q <= 1'b0;
      req_q     <= 1'b0;
      data_q    <= '0;
      stale_q   <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      req_q     <= req_d;
      data_q    <= data_d;
      stale_q   <= stale_d;
    end
  end

  assign disp_data  = data_q;
  assign disp_stale = stale_q;

`ifdef VMEM_ARB_STATS_EN
  logic [15:0] stale_cnt_q, stale_cnt_d;
  logic [15:0] force_cnt_q, force_cnt_d;

  // Saturating event counters
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    force_cnt_d = force_cnt_q;
    if (stale_q && (stale_cnt_q != 16'hFFFF)) begin
      stale_cnt_d = stale_cnt_q + 16'd1;
    end
    if (force_gnt && (force_cnt_q != 16'hFFFF)) begin
      force_cnt_d = force_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stale_cnt_q <= '0;
      force_cnt_q <= '0;
    end else begin
      stale_cnt_q <= stale_cnt_d;
      force_cnt_q <= force_cnt_d;
    end
  end

  assign stale_cnt = stale_cnt_q;
  assign force_cnt = force_cnt_q;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: two instances (MAX_WAIT 8 and 0) on shared
// stimulus, each with its own RAM and a cycle-level reference model.
module tb_vmem_arbiter;
  import vmem_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ram_init;
  logic       disp_req;
  vmem_addr_t disp_addr;
  logic       wr_valid;
  vmem_addr_t wr_addr;
  pixel_t     wr_data;

  pixel_t     disp_data [2];
  logic       disp_stale [2];
  logic       wr_ready [2];
  logic       mem_en [2];
  logic       mem_we [2];
  vmem_addr_t mem_addr [2];
  pixel_t     mem_wdata [2];
  pixel_t     mem_rdata [2];
`ifdef VMEM_ARB_STATS_EN
  logic [15:0] stale_cnt [2];
  logic [15:0] force_cnt [2];
`endif

  always #5 clk = ~clk;

  vmem_arbiter #(.MAX_WAIT(8)) dut8 (
    .clk(clk), .resetn(resetn),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data[0]), .disp_stale(disp_stale[0]),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
`ifdef VMEM_ARB_STATS_EN
    , .stale_cnt(stale_cnt[0]), .force_cnt(force_cnt[0])
`endif
  );

  vmem_arbiter #(.MAX_WAIT(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data[1]), .disp_stale(disp_stale[1]),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
`ifdef VMEM_ARB_STATS_EN
    , .stale_cnt(stale_cnt[1]), .force_cnt(force_cnt[1])
`endif
  );

  // Synchronous RAMs, aliased on the low 8 address bits
  pixel_t ram [2][256];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_init) begin
        for (int i = 0; i < 256; i++) ram[g][i] <= pixel_t'(i * 3);
      end else if (mem_en[g]) begin
        if (mem_we[g]) ram[g][mem_addr[g][7:0]] <= mem_wdata[g];
        else mem_rdata[g] <= ram[g][mem_addr[g][7:0]];
      end
    end
  end

  // Reference model state
  pixel_t     mmem [2][256];
  int         m_wait [2];
  pixel_t     e_data [2];
  logic       e_stale [2];
  int         ev_kind [2];
  pixel_t     ev_val [2];
  int         m_sc [2];
  int         m_fc [2];
  logic       f_q [2];
  logic       x_ready [2];
  logic       x_rd [2];
  logic       x_we [2];
  logic       x_en [2];
  vmem_addr_t x_addr [2];
  pixel_t     x_wdata [2];
  logic       hold_w;
  int         checks = 0;
  int         errors = 0;

  function automatic int mw(input int g);
    return (g == 0) ? 8 : 0;
  endfunction

  task automatic drive(input logic rq, input vmem_addr_t da,
                       input logic wv, input vmem_addr_t wa,
                       input pixel_t wd);
    disp_req = rq; disp_addr = da;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    for (int g = 0; g < 2; g++) begin
      f_q[g]     = resetn && (mw(g) != 0) && (m_wait[g] == mw(g));
      x_ready[g] = resetn && (!rq || f_q[g]);
      x_rd[g]    = resetn && rq && !x_ready[g];
      x_we[g]    = x_ready[g] && wv;
      x_en[g]    = x_rd[g] || x_we[g];
      x_addr[g]  = x_rd[g] ? da : (x_we[g] ? wa : '0);
      x_wdata[g] = x_we[g] ? wd : '0;
    end
    #1;
  endtask

  task automatic tick();
    for (int g = 0; g < 2; g++) begin
      if (!resetn) begin
        m_wait[g] = 0; e_data[g] = '0; e_stale[g] = 1'b0;
        ev_kind[g] = 0; m_sc[g] = 0; m_fc[g] = 0;
      end else begin
        if (e_stale[g] && m_sc[g] < 65535) m_sc[g]++;
        if (f_q[g] && m_fc[g] < 65535) m_fc[g]++;
        if (ev_kind[g] == 1) begin
          e_data[g] = ev_val[g]; e_stale[g] = 1'b0;
        end else if (ev_kind[g] == 2) begin
          e_stale[g] = 1'b1;
        end
        ev_kind[g] = !disp_req ? 0 : (x_rd[g] ? 1 : 2);
        ev_val[g]  = mmem[g][disp_addr[7:0]];
        if (x_we[g]) mmem[g][wr_addr[7:0]] = wr_data;
        if (!wr_valid || x_ready[g]) m_wait[g] = 0;
        else if (m_wait[g] < mw(g)) m_wait[g]++;
      end
    end
    hold_w = resetn && wr_valid && (!x_ready[0] || !x_ready[1]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b0, '0, 1'b1, 19'h00033, 24'h777777);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (wr_ready[g] !== 1'b0 || mem_en[g] !== 1'b0 || mem_we[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d] rdy=%b en=%b we=%b required 0", g,
                 wr_ready[g], mem_en[g], mem_we[g]);
      end
      checks++;
      if (mem_addr[g] !== '0 || mem_wdata[g] !== '0) begin
        errors++;
        $display("FAIL reset_bus[%0d] addr=%h wdata=%h required 0", g,
                 mem_addr[g], mem_wdata[g]);
      end
    end
    tick();
    resetn = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (disp_data[g] !== '0 || disp_stale[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out[%0d] data=%h stale=%b required 0/0", g,
                 disp_data[g], disp_stale[g]);
      end
      checks++;
      if (wr_ready[g] !== 1'b1 || mem_en[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d] rdy=%b en=%b required 1/0", g,
                 wr_ready[g], mem_en[g]);
      end
`ifdef VMEM_ARB_STATS_EN
      checks++;
      if (stale_cnt[g] !== 16'd0 || force_cnt[g] !== 16'd0) begin
        errors++;
        $display("FAIL reset_stats[%0d] sc=%0d fc=%0d required 0", g,
                 stale_cnt[g], force_cnt[g]);
      end
`endif
    end
    tick();
  endtask

  task automatic test_display_stream();
    pixel_t exp;
    for (int i = 0; i < 18; i++) begin
      drive(i < 16, vmem_addr_t'(i), 1'b0, '0, '0);
      exp = (i < 2) ? '0 : pixel_t'((i - 2) * 3);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (disp_data[g] !== exp || disp_stale[g] !== 1'b0) begin
          errors++;
          $display("FAIL stream_data[%0d] i=%0d got %h/%b required %h/0",
                   g, i, disp_data[g], disp_stale[g], exp);
        end
        checks++;
        if (mem_we[g] !== 1'b0) begin
          errors++;
          $display("FAIL stream_we[%0d] i=%0d got %b required 0", g, i,
                   mem_we[g]);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, '0, 1'b1, 19'h12345, 24'h00FF00);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (wr_ready[g] !== 1'b1 || mem_we[g] !== 1'b1 ||
          mem_addr[g] !== 19'h12345 || mem_wdata[g] !== 24'h00FF00) begin
        errors++;
        $display("FAIL wr_idle[%0d] rdy=%b we=%b addr=%h wd=%h required 1/1/12345/00ff00",
                 g, wr_ready[g], mem_we[g], mem_addr[g], mem_wdata[g]);
      end
    end
    tick();
    drive(1'b1, 19'h12345, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (disp_data[g] !== 24'h00FF00) begin
        errors++;
        $display("FAIL rd_back[%0d] got %h required 00ff00", g, disp_data[g]);
      end
    end
    tick();
  endtask

  task automatic test_force();
    pixel_t exp;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vmem_addr_t'(i), 1'b1, 19'h00080, 24'hABCDEF);
      checks++;
      if (wr_ready[0] !== (i == 8) || mem_we[0] !== (i == 8)) begin
        errors++;
        $display("FAIL force_rdy8 i=%0d rdy=%b we=%b required %b", i,
                 wr_ready[0], mem_we[0], (i == 8));
      end
      checks++;
      if (wr_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL force_rdy0 i=%0d got %b required 0", i, wr_ready[1]);
      end
      checks++;
      if (disp_stale[0] !== (i == 10)) begin
        errors++;
        $display("FAIL force_stale i=%0d got %b required %b", i,
                 disp_stale[0], (i == 10));
      end
      if (i >= 2) begin
        exp = (i == 10) ? 24'd21 : pixel_t'((i - 2) * 3);
        checks++;
        if (disp_data[0] !== exp) begin
          errors++;
          $display("FAIL force_data i=%0d got %h required %h", i,
                   disp_data[0], exp);
        end
        checks++;
        if (disp_data[1] !== pixel_t'((i - 2) * 3) || disp_stale[1] !== 1'b0) begin
          errors++;
          $display("FAIL noforce_data i=%0d got %h/%b required %h/0", i,
                   disp_data[1], disp_stale[1], pixel_t'((i - 2) * 3));
        end
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 19'h00080, 24'hABCDEF);
    checks++;
    if (wr_ready[1] !== 1'b1 || mem_we[1] !== 1'b1 || mem_addr[1] !== 19'h00080) begin
      errors++;
      $display("FAIL noforce_wr rdy=%b we=%b addr=%h required 1/1/00080",
               wr_ready[1], mem_we[1], mem_addr[1]);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_drop();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vmem_addr_t'(i + 20), i < 5, 19'h00081, 24'h123456);
      checks++;
      if (mem_we[0] !== 1'b0 || mem_we[1] !== 1'b0) begin
        errors++;
        $display("FAIL drop_we i=%0d got %b/%b required 0/0", i,
                 mem_we[0], mem_we[1]);
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vmem_addr_t'(i + 30), 1'b1, 19'h00081, 24'h123456);
      checks++;
      if (wr_ready[0] !== (i == 8)) begin
        errors++;
        $display("FAIL drop_rearm i=%0d got %b required %b", i,
                 wr_ready[0], (i == 8));
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 19'd5, 1'b0, '0, '0);
    tick();
    drive(1'b1, 19'd6, 1'b1, 19'd9, 24'h55AA55);
    tick();
    resetn = 1'b0;
    drive(1'b1, 19'd7, 1'b1, 19'd9, 24'h55AA55);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (wr_ready[g] !== 1'b0 || mem_en[g] !== 1'b0) begin
        errors++;
        $display("FAIL midrst_ctl[%0d] rdy=%b en=%b required 0/0", g,
                 wr_ready[g], mem_en[g]);
      end
    end
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b0, '0, '0);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (disp_data[g] !== '0 || disp_stale[g] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_out[%0d] k=%0d data=%h stale=%b required 0/0",
                   g, k, disp_data[g], disp_stale[g]);
        end
`ifdef VMEM_ARB_STATS_EN
        checks++;
        if (stale_cnt[g] !== 16'd0 || force_cnt[g] !== 16'd0) begin
          errors++;
          $display("FAIL midrst_stats[%0d] sc=%0d fc=%0d required 0", g,
                   stale_cnt[g], force_cnt[g]);
        end
`endif
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic       rq, wv;
    vmem_addr_t da, wa;
    pixel_t     wd;
    wa = '0;
    wd = '0;
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      rq = ($urandom_range(0, 9) < 7);
      da = vmem_addr_t'($urandom);
      if (!hold_w) begin
        wa = vmem_addr_t'($urandom);
        wd = pixel_t'($urandom);
      end
      wv = ($urandom_range(0, 3) != 0);
      drive(rq, da, wv, wa, wd);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (wr_ready[g] !== x_ready[g] || mem_en[g] !== x_en[g] ||
            mem_we[g] !== x_we[g]) begin
          errors++;
          $display("FAIL rnd_ctl[%0d] n=%0d rdy/en/we=%b%b%b required %b%b%b",
                   g, n, wr_ready[g], mem_en[g], mem_we[g],
                   x_ready[g], x_en[g], x_we[g]);
        end
        if (x_en[g]) begin
          checks++;
          if (mem_addr[g] !== x_addr[g]) begin
            errors++;
            $display("FAIL rnd_addr[%0d] n=%0d got %h required %h", g, n,
                     mem_addr[g], x_addr[g]);
          end
        end
        if (x_we[g]) begin
          checks++;
          if (mem_wdata[g] !== x_wdata[g]) begin
            errors++;
            $display("FAIL rnd_wdata[%0d] n=%0d got %h required %h", g, n,
                     mem_wdata[g], x_wdata[g]);
          end
        end
        checks++;
        if (disp_data[g] !== e_data[g] || disp_stale[g] !== e_stale[g]) begin
          errors++;
          $display("FAIL rnd_disp[%0d] n=%0d got %h/%b required %h/%b", g, n,
                   disp_data[g], disp_stale[g], e_data[g], e_stale[g]);
        end
`ifdef VMEM_ARB_STATS_EN
        checks++;
        if (stale_cnt[g] !== 16'(m_sc[g]) || force_cnt[g] !== 16'(m_fc[g])) begin
          errors++;
          $display("FAIL rnd_stats[%0d] n=%0d sc=%0d fc=%0d required %0d/%0d",
                   g, n, stale_cnt[g], force_cnt[g], m_sc[g], m_fc[g]);
        end
`endif
      end
      tick();
    end
    resetn = 1'b1;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 256; i++) mmem[g][i] = pixel_t'(i * 3);
      m_wait[g] = 0; e_data[g] = '0; e_stale[g] = 1'b0;
      ev_kind[g] = 0; ev_val[g] = '0; m_sc[g] = 0; m_fc[g] = 0;
    end
    hold_w = 1'b0;
    resetn = 1'b0;
    ram_init = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    test_reset();
    test_display_stream();
    test_write_read();
    test_force();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
